// File: rtl/pdm_modulator.sv
// pdm_modulator: PCM to PDM converter using a second-order sigma-delta loop with a one-deep sample buffer
module pdm_modulator #(
    parameter int DIV = 16,
    parameter int OSR = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pcm_in,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    output logic        pdm_clk,
    output logic        pdm_out,
    output logic        underrun,
    input  logic        underrun_clr
);
    logic [6:0] div_cnt;
    logic [11:0] bit_cnt;
    logic signed [15:0] hold, act;
    logic hold_full;
    logic signed [23:0] acc1, acc2, x, fb, nxt1, nxt2;
    logic signed [25:0] sum1, sum2;
    logic div_wrap, step, frame, xfer;

    function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
        return v > 26'sd8388607 ? 24'sd8388607 : v < -26'sd8388608 ? -24'sd8388608 : $signed(v[23:0]);
    endfunction

    assign div_wrap = div_cnt == 7'(DIV - 1);
    assign step = div_wrap && !pdm_clk;
    assign frame = step && bit_cnt == 12'(OSR - 1);
    assign pcm_ready = !hold_full;
    assign xfer = pcm_valid && pcm_ready;

    // input limited to 0.75 full scale keeps the second-order loop stable
    always_comb begin
        x = act > 16'sd24576 ? 24'sd24576 : act < -16'sd24576 ? -24'sd24576 : 24'(act);
        fb = pdm_out ? 24'sd32768 : -24'sd32768;
        sum1 = 26'(acc1) + 26'(x) - 26'(fb);
        nxt1 = sat24(sum1);
        sum2 = 26'(acc2) + 26'(nxt1) - 26'(fb);
        nxt2 = sat24(sum2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            pdm_clk <= 1'b0;
            pdm_out <= 1'b0;
            acc1 <= '0;
            acc2 <= '0;
            act <= '0;
            hold <= '0;
            hold_full <= 1'b0;
            underrun <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 7'd1;
            if (div_wrap) pdm_clk <= !pdm_clk;
            if (step) begin
                bit_cnt <= frame ? '0 : bit_cnt + 12'd1;
                acc1 <= nxt1;
                acc2 <= nxt2;
                pdm_out <= !nxt2[23];
            end
            if (frame && hold_full) act <= hold;
            if (xfer) hold <= pcm_in;
            hold_full <= xfer || (hold_full && !frame);
            underrun <= (frame && !hold_full) || (underrun && !underrun_clr);
        end
    end
endmodule

// File: doc/pdm_modulator.md
# pdm_modulator

PCM-to-PDM modulator: the transmit-direction counterpart of the CIC PDM decimator. It accepts signed 16-bit PCM samples over a valid/ready handshake and produces a 1-bit pulse-density stream plus its bit clock, generated by a second-order sigma-delta loop. Its main uses are:
- generating microphone-like stimulus for the decimation chain in simulation and on hardware loopback;
- driving a PDM output such as a speaker amplifier.

## Interface
Parameters:
- DIV, 16: clk cycles per pdm_clk half-period, so one PDM bit lasts 2*DIV clk cycles; legal range 1..127.
- OSR, 64: PDM bits per PCM sample (oversampling ratio); legal range 2..4096.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low; asserts immediately, released synchronously to clk by the integrator.
- pcm_in  in  16  signed two's-complement sample.
- pcm_valid  in  1  pcm_in is valid this cycle.
- pcm_ready  out  1  the holding register can accept a sample.
- pdm_clk  out  1  PDM bit clock, 50 % duty cycle.
- pdm_out  out  1  PDM data; changes only on the clk edge where pdm_clk rises.
- underrun  out  1  sticky flag: a frame boundary occurred with no sample buffered.
- underrun_clr  in  1  clears underrun (synchronous, single cycle).

## Operation
Clock divider:
- div_cnt counts 0..DIV-1. On each cycle with div_cnt==DIV-1 it wraps to 0 and pdm_clk toggles.
- A modulator step fires on the cycle where pdm_clk goes 0->1.

Sample buffering:
- The block holds a one-entry holding register (hold, hold_full) and an active sample register (act).
- pcm_ready = !hold_full.
- A transfer occurs when pcm_valid && pcm_ready; pcm_in is stored in hold and hold_full is set.

Frame counter:
- bit_cnt counts 0..OSR-1 and advances on each step.
- On the step where bit_cnt==OSR-1 (frame boundary), bit_cnt wraps to 0 and the next sample is handled as follows:
  - hold_full=1: act<=hold and hold_full<=0.
  - hold_full=0: act is kept (repeat the previous sample) and underrun<=1.
- If a transfer and a frame-boundary load occur in the same cycle, the load takes the old hold contents. The new sample goes into hold and hold_full stays 1.
- underrun_clr and a new underrun in the same cycle: the set wins.

Modulator (evaluated on each step, 24-bit signed arithmetic):
- x = act clamped to [-24576, +24576] (0.75 full scale), then sign-extended.
- fb = +32768 if the current pdm_out is 1, else -32768.
- acc1' = sat24(acc1 + x - fb).
- acc2' = sat24(acc2 + acc1' - fb).
- pdm_out' = (acc2' >= 0).
- sat24 saturates to [-2^23, 2^23-1]; an accumulator never wraps.

## Timing
- Reset values: pdm_clk=0, pdm_out=0, pcm_ready=1, underrun=0, div_cnt=0, bit_cnt=0, hold_full=0, act=0, acc1=acc2=0.
- The first pdm_clk rise and the first step occur DIV clk cycles after reset release. Steps then repeat every 2*DIV cycles.
- pdm_out stays stable for the full pdm_clk period. It is valid at the pdm_clk falling edge, where receivers sample it.
- pcm_ready falls the cycle after a transfer. It rises the cycle after the frame-boundary load.
- Sample latency: the sample in act first affects pdm_out on the step following the frame boundary that loaded it.
- Reset asserted mid-frame clears all state immediately. A partially streamed sample and the hold contents are discarded.
- DIV=1: pdm_clk toggles every cycle, so there is a step every 2 cycles. Behaviour is otherwise unchanged.

## Test plan
- Reset check: release reset with DIV=16 and OSR=64 -> all outputs are at their reset values. The first pdm_clk rise occurs at cycle 16 after release and the period is 32 cycles.
- Zero input: hold pcm_in=0 streamed continuously -> the first seven pdm_out bits are 1,1,0,1,0,0,1. The ones count over 1024 bits is 512±4.
- Constant +16384 streamed continuously -> ones density over 4096 bits is 75%±1%. Constant -16384 -> ones density is 25%±1%.
- Clamp: pcm_in=+32767 -> the bitstream is identical to pcm_in=+24576 over 4096 bits, and acc1/acc2 never saturate.
- Handshake and underrun, in sequence:
  1. Keep pcm_valid high -> exactly one sample is accepted per 64 bits and pcm_ready is low between accepts.
  2. Drop pcm_valid for one frame -> underrun=1 at that boundary and act repeats.
  3. Assert underrun_clr -> underrun=0.
- Loopback: PDM decimator (OSR=64) driven by pdm_clk/pdm_out with a ±16384 square wave at 1/8 of the sample rate -> decimated output within ±2 % of the input after the filter settles.
